// File: rtl/rgmii_tx_framer.sv
// RGMII transmit framer: wraps a byte stream with preamble/SFD, flags payload
// underruns with TX_ER, and enforces the inter-frame gap before the next frame.
module rgmii_tx_framer #(
    parameter int IFG_BYTES = 12
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_data,
    input  logic       i_last,
    output logic [3:0] o_d_rise,
    output logic [3:0] o_d_fall,
    output logic       o_ctl_rise,
    output logic       o_ctl_fall,
    output logic       o_underrun,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DRAIN,
        S_IFG
    } state_t;

    localparam logic [3:0] IFG_LAST = 4'(IFG_BYTES - 1);

    state_t     r_state;
    state_t     w_state_nx;
    logic [2:0] r_pre_cnt;
    logic [2:0] w_pre_cnt_nx;
    logic [3:0] r_ifg_cnt;
    logic [3:0] w_ifg_cnt_nx;
    logic [7:0] r_byte;
    logic [7:0] w_byte_nx;
    logic       r_tx_en;
    logic       w_tx_en_nx;
    logic       r_tx_en_xor_er;
    logic       w_tx_en_xor_er_nx;
    logic       r_underrun;
    logic       w_underrun_nx;

    // Outputs are computed from the current state and registered, so the
    // line stream trails the state sequence by exactly one byte clock.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_pre_cnt      <= 3'd0;
            r_ifg_cnt      <= 4'd0;
            r_byte         <= 8'h00;
            r_tx_en        <= 1'b0;
            r_tx_en_xor_er <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_pre_cnt      <= w_pre_cnt_nx;
            r_ifg_cnt      <= w_ifg_cnt_nx;
            r_byte         <= w_byte_nx;
            r_tx_en        <= w_tx_en_nx;
            r_tx_en_xor_er <= w_tx_en_xor_er_nx;
            r_underrun     <= w_underrun_nx;
        end
    end

    always_comb begin
        w_state_nx        = r_state;
        w_pre_cnt_nx      = r_pre_cnt;
        w_ifg_cnt_nx      = r_ifg_cnt;
        w_byte_nx         = 8'h00;
        w_tx_en_nx        = 1'b0;
        w_tx_en_xor_er_nx = 1'b0;
        w_underrun_nx     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pre_cnt_nx = 3'd0;
                w_ifg_cnt_nx = 4'd0;
                if (i_valid) begin
                    w_state_nx = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                w_tx_en_nx        = 1'b1;
                w_tx_en_xor_er_nx = 1'b1;
                if (r_pre_cnt == 3'd7) begin
                    w_byte_nx    = 8'hD5;
                    w_pre_cnt_nx = 3'd0;
                    w_state_nx   = S_DATA;
                end else begin
                    w_byte_nx    = 8'h55;
                    w_pre_cnt_nx = r_pre_cnt + 3'd1;
                end
            end
            S_DATA: begin
                if (i_valid) begin
                    w_byte_nx         = i_data;
                    w_tx_en_nx        = 1'b1;
                    w_tx_en_xor_er_nx = 1'b1;
                    if (i_last) begin
                        w_ifg_cnt_nx = 4'd0;
                        w_state_nx   = S_IFG;
                    end
                end else begin
                    // Underrun: one TX_EN+TX_ER byte corrupts the frame on the wire.
                    w_tx_en_nx    = 1'b1;
                    w_underrun_nx = 1'b1;
                    w_state_nx    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_valid && i_last) begin
                    w_ifg_cnt_nx = 4'd0;
                    w_state_nx   = S_IFG;
                end
            end
            S_IFG: begin
                if (r_ifg_cnt == IFG_LAST) begin
                    w_ifg_cnt_nx = 4'd0;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_ifg_cnt_nx = r_ifg_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nx   = S_IDLE;
                w_pre_cnt_nx = 3'd0;
                w_ifg_cnt_nx = 4'd0;
            end
        endcase
    end

    assign o_ready    = (r_state == S_DATA) || (r_state == S_DRAIN);
    assign o_busy     = (r_state != S_IDLE);
    assign o_d_rise   = r_byte[3:0];
    assign o_d_fall   = r_byte[7:4];
    assign o_ctl_rise = r_tx_en;
    assign o_ctl_fall = r_tx_en_xor_er;
    assign o_underrun = r_underrun;

endmodule

// File: doc/rgmii_tx_framer.md
RGMII_TX_FRAMER -- requirements
Module: rgmii_tx_framer

Interface
REQ-001 SHALL have parameter IFG_BYTES, default 12, inter-frame gap length in byte clocks; legal range 1..15.
REQ-002 SHALL have port i_clk  input  1  byte clock (125 MHz), all logic on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  payload byte valid.
REQ-005 SHALL have port o_ready  output  1  payload byte accepted when i_valid && o_ready.
REQ-006 SHALL have port i_data  input  8  payload byte.
REQ-007 SHALL have port i_last  input  1  final byte of frame, qualified by i_valid.
REQ-008 SHALL have port o_d_rise  output  4  nibble for ODDR rising edge (byte bits [3:0]).
REQ-009 SHALL have port o_d_fall  output  4  nibble for ODDR falling edge (byte bits [7:4]).
REQ-010 SHALL have port o_ctl_rise  output  1  TX_EN for ODDR rising edge.
REQ-011 SHALL have port o_ctl_fall  output  1  TX_EN xor TX_ER for ODDR falling edge.
REQ-012 SHALL have port o_underrun  output  1  one-cycle pulse on payload underrun.
REQ-013 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, PREAMBLE, DATA, DRAIN, IFG; o_d_*, o_ctl_* and o_underrun are registered outputs.
REQ-015 SHALL, in IDLE, drive data 0x00, ctl_rise=0, ctl_fall=0, o_ready=0.
REQ-016 SHALL move IDLE->PREAMBLE on the cycle i_valid is seen high in IDLE, without consuming the byte.
REQ-017 SHALL, from PREAMBLE entry, output seven bytes 0x55 then one byte 0xD5 (eight cycles), ctl_rise=ctl_fall=1, then enter DATA; first preamble byte appears one cycle after i_valid rose.
REQ-018 SHALL drive o_ready = 1 exactly while state is DATA or DRAIN (decoded from state, not registered separately).
REQ-019 SHALL, in DATA with i_valid=1, register i_data to outputs next cycle with ctl_rise=ctl_fall=1 (one byte per clock, latency 1).
REQ-020 SHALL, in DATA with i_valid && i_last, go to IFG after outputting that byte.
REQ-021 SHALL, in DATA with i_valid=0 (underrun), output next cycle data 0x00, ctl_rise=1, ctl_fall=0 (TX_ER), pulse o_underrun, and enter DRAIN.
REQ-022 SHALL, in DRAIN, output idle (data 0, ctl 0/0), accept and discard beats, and go to IFG after the beat with i_valid && i_last.
REQ-023 SHALL, in IFG, output idle for exactly IFG_BYTES cycles, then return to IDLE; i_valid is ignored during IFG.
REQ-024 SHALL treat i_last on the first DATA beat as a one-byte payload (no padding, no FCS insertion; upstream supplies both).
REQ-025 SHALL hold the IFG counter at 4 bits and the preamble counter at 3 bits, with no wrap beyond the stated counts.
REQ-026 SHALL never emit TX_EN=1 outside PREAMBLE/DATA output cycles and the single underrun-error cycle.

Reset
REQ-027 SHALL, on i_reset assertion, immediately (asynchronously) force state IDLE, all counters 0, o_d_rise=o_d_fall=0, o_ctl_rise=o_ctl_fall=0, o_underrun=0, o_busy=0, o_ready=0.
REQ-028 SHALL, if reset occurs mid-frame, not resume the frame; the next frame after release starts with a full preamble.
REQ-029 SHALL begin operation on the first i_clk edge after i_reset deasserts.

Verification
REQ-030 SHALL cover: 3-byte frame 0x11,0x22,0x33 (last on 0x33) -> 7x0x55, 0xD5, 0x11, 0x22, 0x33 with ctl 1/1, then 12 idle cycles, then IDLE.
REQ-031 SHALL cover: one-byte frame 0xA5 with i_last -> preamble, SFD, nibbles rise=0x5 fall=0xA, then IFG.
REQ-032 SHALL cover: i_valid drops after 2 payload bytes, then 4 beats with last on 4th -> one cycle ctl 1/0 data 0, o_underrun single pulse, DRAIN consumes 4 beats, IFG of 12.
REQ-033 SHALL cover: back-to-back frames with i_valid held high through IFG -> o_ready=0 for 12 IFG cycles plus one IDLE cycle and 8 preamble cycles; second frame bytes intact.
REQ-034 SHALL cover: i_reset pulsed during payload byte 5 -> outputs zero asynchronously, next frame shows full 8-byte preamble/SFD.
REQ-035 SHALL cover: IFG_BYTES=1 -> exactly one idle cycle between last payload byte and IDLE.
